// File: rtl/cpu_riscv_multicycle_if.sv
// rtl/cpu_riscv_multicycle_if.sv - bus bundle between the multi-cycle core and its memories/debugger
interface cpu_riscv_multicycle_if #(
   parameter int ADDRWIDTH = 32
);
   logic [ADDRWIDTH-1:0] oIM_Addr;
   logic                 oIM_Req;
   logic                 iIM_Ready;
   logic [31:0]          iIM_Data;
   logic [ADDRWIDTH-1:0] oAB;
   logic [31:0]          oWriteData;
   logic                 oRD;
   logic                 oWR;
   logic                 iDM_Ready;
   logic [31:0]          iReadData;
   logic [ADDRWIDTH-1:0] oCurrent_PC;
   logic                 oFetch;
   logic [2:0]           oState;
   logic                 oHalt;
   logic [4:0]           iDbg_RA;
   logic [31:0]          oDbg_RD;

   modport master (
      output oIM_Addr, oIM_Req, oAB, oWriteData, oRD, oWR,
             oCurrent_PC, oFetch, oState, oHalt, oDbg_RD,
      input  iIM_Ready, iIM_Data, iDM_Ready, iReadData, iDbg_RA
   );

   modport slave (
      input  oIM_Addr, oIM_Req, oAB, oWriteData, oRD, oWR,
             oCurrent_PC, oFetch, oState, oHalt, oDbg_RD,
      output iIM_Ready, iIM_Data, iDM_Ready, iReadData, iDbg_RA
   );
endinterface

// File: rtl/cpu_riscv_multicycle.sv
// rtl/cpu_riscv_multicycle.sv - multi-cycle RV32I-subset core; CPU_MC_ILLEGAL_TRAP_EN halts on illegal instructions
module cpu_riscv_multicycle #(
   parameter int          ADDRWIDTH = 32,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          NREGS     = 32
) (
   input  logic                   iCPU_Clk,
   input  logic                   iCPU_Reset,
   cpu_riscv_multicycle_if.master bus
);
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   state_t               state, state_n;
   logic [ADDRWIDTH-1:0] pc, pc_plus4;
   logic [31:0]          ir, a, b, alu_out, mdr, alu_res;
   logic [31:0]          regs [0:NREGS-1];
   logic                 im_req, rd_o, wr_o, halt_o;

   // Instruction fields and immediates decoded straight from IR, which is stable after FETCH.
   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic [4:0]  rd, rs1, rs2;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   assign opcode = ir[6:0];
   assign rd     = ir[11:7];
   assign funct3 = ir[14:12];
   assign rs1    = ir[19:15];
   assign rs2    = ir[24:20];
   assign funct7 = ir[31:25];
   assign imm_i  = {{20{ir[31]}}, ir[31:20]};
   assign imm_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
   assign imm_b  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
   assign imm_u  = {ir[31:12], 12'b0};
   assign imm_j  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

   logic is_addi, is_rtype, is_lui, is_lw, is_sw, is_br, is_jal, is_alu, legal, taken, rd_ok;
   assign is_addi  = (opcode == 7'b0010011) && (funct3 == 3'b000);
   assign is_rtype = (opcode == 7'b0110011) &&
                     (((funct7 == 7'b0000000) && (funct3 inside {3'b000, 3'b111, 3'b110, 3'b100, 3'b010})) ||
                      ((funct7 == 7'b0100000) && (funct3 == 3'b000)));
   assign is_lui   = (opcode == 7'b0110111);
   assign is_lw    = (opcode == 7'b0000011) && (funct3 == 3'b010);
   assign is_sw    = (opcode == 7'b0100011) && (funct3 == 3'b010);
   assign is_br    = (opcode == 7'b1100011) && (funct3[2:1] == 2'b00);
   assign is_jal   = (opcode == 7'b1101111);
   assign is_alu   = is_addi | is_rtype | is_lui;
   assign taken    = funct3[0] ? (a != b) : (a == b);
   assign rd_ok    = (rd != 5'd0) && (int'(rd) < NREGS);
   assign pc_plus4 = pc + ADDRWIDTH'(4);

`ifdef CPU_MC_ILLEGAL_TRAP_EN
   // Register indices beyond the implemented file (RV32E) are only illegal in fields the format uses.
   logic bad_idx;
   assign bad_idx = ((is_alu | is_lw | is_jal) && (int'(rd) >= NREGS)) ||
                    ((is_addi | is_rtype | is_lw | is_sw | is_br) && (int'(rs1) >= NREGS)) ||
                    ((is_rtype | is_sw | is_br) && (int'(rs2) >= NREGS));
   assign legal   = (is_alu | is_lw | is_sw | is_br | is_jal) && !bad_idx;
`else
   assign legal   = is_alu | is_lw | is_sw | is_br | is_jal;
`endif

   // x0 and unimplemented indices always read as zero.
   function automatic logic [31:0] rf_read(input logic [4:0] idx);
      if (idx == 5'd0 || int'(idx) >= NREGS) return 32'd0;
      return regs[idx];
   endfunction

   // ALU result for R-type, ADDI and LUI; SLT is a signed compare.
   always_comb begin
      alu_res = 32'd0;
      if (is_lui)       alu_res = imm_u;
      else if (is_addi) alu_res = a + imm_i;
      else begin
         case (funct3)
            3'b000:  alu_res = ir[30] ? (a - b) : (a + b);
            3'b111:  alu_res = a & b;
            3'b110:  alu_res = a | b;
            3'b100:  alu_res = a ^ b;
            3'b010:  alu_res = {31'd0, $signed(a) < $signed(b)};
            default: alu_res = 32'd0;
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge iCPU_Clk) begin
      if (iCPU_Reset) state <= S_FETCH;
      else            state <= state_n;
   end

   // Next state and bus strobes; strobes are gated by reset so an access dies in the cycle reset appears.
   always_comb begin
      state_n = state;
      im_req  = 1'b0;
      rd_o    = 1'b0;
      wr_o    = 1'b0;
      halt_o  = 1'b0;
      case (state)
         S_FETCH: begin
            im_req = 1'b1;
            if (bus.iIM_Ready) state_n = S_DECODE;
         end
         S_DECODE: state_n = S_EXEC;
         S_EXEC: begin
            if (!legal) begin
`ifdef CPU_MC_ILLEGAL_TRAP_EN
               state_n = S_HALT;
`else
               state_n = S_FETCH;
`endif
            end
            else if (is_alu || is_jal) state_n = S_WB;
            else if (is_lw || is_sw)   state_n = S_MEM;
            else                       state_n = S_FETCH;
         end
         S_MEM: begin
            rd_o = is_lw;
            wr_o = is_sw;
            if (bus.iDM_Ready) state_n = is_lw ? S_WB : S_FETCH;
         end
         S_WB: state_n = S_FETCH;
         S_HALT: begin
`ifdef CPU_MC_ILLEGAL_TRAP_EN
            halt_o = 1'b1;
`endif
         end
         default: state_n = S_FETCH;
      endcase
      if (iCPU_Reset) begin
         rd_o   = 1'b0;
         wr_o   = 1'b0;
         halt_o = 1'b0;
      end
   end

   // Datapath registers, PC and register file; the register file is only written in WB.
   always_ff @(posedge iCPU_Clk) begin
      if (iCPU_Reset) begin
         pc      <= RESET_PC[ADDRWIDTH-1:0];
         ir      <= 32'd0;
         a       <= 32'd0;
         b       <= 32'd0;
         alu_out <= 32'd0;
         mdr     <= 32'd0;
         regs    <= '{default: 32'd0};
      end
      else begin
         case (state)
            S_FETCH:  if (bus.iIM_Ready) ir <= bus.iIM_Data;
            S_DECODE: begin
               a <= rf_read(rs1);
               b <= rf_read(rs2);
            end
            S_EXEC: begin
               if (!legal) begin
`ifndef CPU_MC_ILLEGAL_TRAP_EN
                  pc <= pc_plus4;
`endif
               end
               else if (is_alu) alu_out <= alu_res;
               else if (is_lw)  alu_out <= a + imm_i;
               else if (is_sw)  alu_out <= a + imm_s;
               else if (is_br)  pc <= taken ? (pc + imm_b[ADDRWIDTH-1:0]) : pc_plus4;
               else begin
                  alu_out <= 32'(pc_plus4);
                  pc      <= pc + imm_j[ADDRWIDTH-1:0];
               end
            end
            S_MEM: begin
               if (bus.iDM_Ready) begin
                  if (is_lw) mdr <= bus.iReadData;
                  else       pc  <= pc_plus4;
               end
            end
            S_WB: begin
               if (rd_ok) regs[rd] <= is_lw ? mdr : alu_out;
               if (!is_jal) pc <= pc_plus4;
            end
            default: ;
         endcase
      end
   end

   assign bus.oIM_Addr    = pc;
   assign bus.oIM_Req     = im_req;
   assign bus.oAB         = alu_out[ADDRWIDTH-1:0];
   assign bus.oWriteData  = b;
   assign bus.oRD         = rd_o;
   assign bus.oWR         = wr_o;
   assign bus.oCurrent_PC = pc;
   assign bus.oFetch      = (state == S_FETCH);
   assign bus.oState      = state;
   assign bus.oHalt       = halt_o;
   assign bus.oDbg_RD     = rf_read(bus.iDbg_RA);
endmodule

// File: tb/tb_cpu_riscv_multicycle.sv
// tb/tb_cpu_riscv_multicycle.sv - self-checking bench for cpu_riscv_multicycle
module tb_cpu_riscv_multicycle;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   failures = 0;

   cpu_riscv_multicycle_if #(.ADDRWIDTH(32)) bus();

   cpu_riscv_multicycle #(.ADDRWIDTH(32), .RESET_PC(32'h0), .NREGS(32)) dut (
      .iCPU_Clk  (clk),
      .iCPU_Reset(rst),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   typedef struct { int rd; logic [31:0] val; } reg_exp_t;
   typedef struct { logic [31:0] addr; logic [31:0] data; } store_t;

   reg_exp_t    reg_q[$];
   store_t      exp_store_q[$];
   store_t      obs_store_q[$];
   logic [31:0] model [0:31];
   logic [31:0] dmem [logic [31:0]];
   logic [31:0] cur_instr, exp_pc, obs_ab, obs_wd;
   int          im_stall, dm_stall, obs_wr, obs_rd, obs_unstable;

   localparam logic [31:0] NOP = 32'h00000013;

   // One clock: memory models answer the current request, then the edge.
   task automatic tick();
      bus.iIM_Data = cur_instr;
      if (bus.oIM_Req) begin
         if (im_stall > 0) begin bus.iIM_Ready = 1'b0; im_stall--; end
         else bus.iIM_Ready = 1'b1;
      end
      if (bus.oRD || bus.oWR) begin
         if (dm_stall > 0) begin bus.iDM_Ready = 1'b0; dm_stall--; end
         else begin
            bus.iDM_Ready = 1'b1;
            if (bus.oWR) begin
               obs_store_q.push_back('{bus.oAB, bus.oWriteData});
               dmem[bus.oAB] = bus.oWriteData;
            end
            if (bus.oRD) bus.iReadData = dmem.exists(bus.oAB) ? dmem[bus.oAB] : 32'd0;
         end
      end
      @(posedge clk);
      #1;
      bus.iIM_Ready = 1'b0;
      bus.iDM_Ready = 1'b0;
   endtask

   // Run until the core leaves FETCH and comes back; cycles=-1 if that never happens.
   task automatic exec_one(output int cycles);
      logic left, first;
      cycles = 0; left = 1'b0; first = 1'b1;
      obs_wr = 0; obs_rd = 0; obs_unstable = 0;
      while (cycles < 60) begin
         if (bus.oState == 3'd3 && (bus.oWR || bus.oRD)) begin
            if (bus.oWR) obs_wr++;
            if (bus.oRD) obs_rd++;
            if (first) begin obs_ab = bus.oAB; obs_wd = bus.oWriteData; first = 1'b0; end
            else if (bus.oAB !== obs_ab || bus.oWriteData !== obs_wd) obs_unstable++;
         end
         tick();
         cycles++;
         if (bus.oState != 3'd0) left = 1'b1;
         else if (left) break;
      end
      if (!(left && bus.oState == 3'd0)) cycles = -1;
   endtask

   task automatic rd_reg(input int idx, output logic [31:0] v);
      bus.iDbg_RA = 5'(idx);
      @(negedge clk);
      v = bus.oDbg_RD;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      exp_pc = 32'd0;
   endtask

   task automatic run_nops(input int n);
      int cyc;
      cur_instr = NOP;
      for (int i = 0; i < n; i++) begin exec_one(cyc); exp_pc += 4; end
   endtask

   task automatic test_reset();
      logic [31:0] v;
      do_reset();
      checks++; if (bus.oState !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", bus.oState); end
      checks++; if (bus.oFetch !== 1'b1 || bus.oIM_Req !== 1'b1) begin failures++; $display("FAIL reset_fetch got=%b%b exp=11", bus.oFetch, bus.oIM_Req); end
      checks++; if (bus.oCurrent_PC !== 32'd0 || bus.oIM_Addr !== 32'd0) begin failures++; $display("FAIL reset_pc got=%h exp=0", bus.oCurrent_PC); end
      checks++; if (bus.oRD !== 1'b0 || bus.oWR !== 1'b0 || bus.oHalt !== 1'b0) begin failures++; $display("FAIL reset_strobes got=%b%b%b exp=000", bus.oRD, bus.oWR, bus.oHalt); end
      for (int i = 0; i < 32; i++) begin
         rd_reg(i, v);
         checks++; if (v !== 32'd0) begin failures++; $display("FAIL reset_reg x%0d got=%h exp=0", i, v); end
      end
   endtask

   task automatic test_addi();
      int cyc; logic [31:0] v; reg_exp_t e;
      cur_instr = 32'h00500093;
      reg_q.push_back('{1, 32'd5}); model[1] = 32'd5;
      exec_one(cyc); exp_pc += 4;
      checks++; if (cyc !== 4) begin failures++; $display("FAIL addi_cycles got=%0d exp=4", cyc); end
      checks++; if (bus.oFetch !== 1'b1) begin failures++; $display("FAIL addi_fetch got=%b exp=1", bus.oFetch); end
      checks++; if (bus.oCurrent_PC !== exp_pc) begin failures++; $display("FAIL addi_pc got=%h exp=%h", bus.oCurrent_PC, exp_pc); end
      e = reg_q.pop_front(); rd_reg(e.rd, v);
      checks++; if (v !== e.val) begin failures++; $display("FAIL addi_x1 got=%h exp=%h", v, e.val); end
   endtask

   task automatic test_alu();
      logic [31:0] prog [10];
      int          rds  [10];
      logic [31:0] vals [10];
      int cyc; logic [31:0] v; reg_exp_t e;
      prog = '{32'hFFD00113, 32'h002081B3, 32'h40208233, 32'h00700013, 32'h0020F333,
               32'h0020E3B3, 32'h0020C433, 32'h001124B3, 32'h0020A533, 32'h123455B7};
      rds  = '{2, 3, 4, 0, 6, 7, 8, 9, 10, 11};
      vals = '{32'hFFFFFFFD, 32'd2, 32'd8, 32'd0, 32'd5,
               32'hFFFFFFFD, 32'hFFFFFFF8, 32'd1, 32'd0, 32'h12345000};
      for (int i = 0; i < 10; i++) begin
         cur_instr = prog[i];
         reg_q.push_back('{rds[i], vals[i]});
         if (rds[i] != 0) model[rds[i]] = vals[i];
         exec_one(cyc); exp_pc += 4;
         checks++; if (cyc !== 4) begin failures++; $display("FAIL alu_cycles[%0d] got=%0d exp=4", i, cyc); end
         checks++; if (bus.oCurrent_PC !== exp_pc) begin failures++; $display("FAIL alu_pc[%0d] got=%h exp=%h", i, bus.oCurrent_PC, exp_pc); end
         e = reg_q.pop_front(); rd_reg(e.rd, v);
         checks++; if (v !== e.val) begin failures++; $display("FAIL alu_reg[%0d] x%0d got=%h exp=%h", i, e.rd, v, e.val); end
      end
   endtask

   task automatic test_mem();
      int cyc; logic [31:0] v; reg_exp_t e; store_t se, so;
      cur_instr = 32'h04102023; dm_stall = 3;
      exp_store_q.push_back('{32'h40, model[1]});
      exec_one(cyc); exp_pc += 4;
      checks++; if (cyc !== 7) begin failures++; $display("FAIL sw_cycles got=%0d exp=7", cyc); end
      checks++; if (obs_wr !== 4 || obs_unstable !== 0) begin failures++; $display("FAIL sw_hold got=wr%0d/unstable%0d exp=wr4/unstable0", obs_wr, obs_unstable); end
      checks++; if (obs_ab !== 32'h40 || obs_wd !== 32'd5) begin failures++; $display("FAIL sw_bus got=%h/%h exp=40/5", obs_ab, obs_wd); end
      se = exp_store_q.pop_front();
      checks++;
      if (obs_store_q.size() != 1) begin failures++; $display("FAIL sw_count got=%0d exp=1", obs_store_q.size()); end
      else begin
         so = obs_store_q.pop_front();
         if (so.addr !== se.addr || so.data !== se.data) begin failures++; $display("FAIL sw_store got=%h:%h exp=%h:%h", so.addr, so.data, se.addr, se.data); end
      end
      checks++; if (bus.oCurrent_PC !== exp_pc) begin failures++; $display("FAIL sw_pc got=%h exp=%h", bus.oCurrent_PC, exp_pc); end
      cur_instr = 32'h04002283; dm_stall = 3;
      reg_q.push_back('{5, model[1]}); model[5] = model[1];
      exec_one(cyc); exp_pc += 4;
      checks++; if (cyc !== 8) begin failures++; $display("FAIL lw_cycles got=%0d exp=8", cyc); end
      checks++; if (obs_rd !== 4 || obs_unstable !== 0 || obs_ab !== 32'h40) begin failures++; $display("FAIL lw_hold got=rd%0d/unstable%0d/%h exp=rd4/unstable0/40", obs_rd, obs_unstable, obs_ab); end
      e = reg_q.pop_front(); rd_reg(e.rd, v);
      checks++; if (v !== e.val) begin failures++; $display("FAIL lw_x5 got=%h exp=%h", v, e.val); end
      checks++; if (bus.oCurrent_PC !== exp_pc) begin failures++; $display("FAIL lw_pc got=%h exp=%h", bus.oCurrent_PC, exp_pc); end
   endtask

   task automatic test_branch();
      int cyc; logic [31:0] v;
      do_reset();
      run_nops(4);
      cur_instr = 32'hFE000CE3; exec_one(cyc); exp_pc = 32'h08;
      checks++; if (cyc !== 3 || bus.oCurrent_PC !== exp_pc) begin failures++; $display("FAIL beq got=%0d/%h exp=3/%h", cyc, bus.oCurrent_PC, exp_pc); end
      run_nops(2);
      cur_instr = 32'hFE001CE3; exec_one(cyc); exp_pc = 32'h14;
      checks++; if (cyc !== 3 || bus.oCurrent_PC !== exp_pc) begin failures++; $display("FAIL bne got=%0d/%h exp=3/%h", cyc, bus.oCurrent_PC, exp_pc); end
      run_nops(3);
      cur_instr = 32'h010000EF; model[1] = 32'h24; exec_one(cyc); exp_pc = 32'h30;
      checks++; if (cyc !== 4 || bus.oCurrent_PC !== exp_pc) begin failures++; $display("FAIL jal got=%0d/%h exp=4/%h", cyc, bus.oCurrent_PC, exp_pc); end
      rd_reg(1, v);
      checks++; if (v !== model[1]) begin failures++; $display("FAIL jal_link got=%h exp=%h", v, model[1]); end
   endtask

   task automatic test_fetch_stall();
      int cyc;
      im_stall = 5; cur_instr = NOP;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (bus.oState !== 3'd0 || bus.oCurrent_PC !== exp_pc) begin failures++; $display("FAIL stall[%0d] got=%0d/%h exp=0/%h", i, bus.oState, bus.oCurrent_PC, exp_pc); end
      end
      exec_one(cyc); exp_pc += 4;
      checks++; if (cyc !== 4 || bus.oCurrent_PC !== exp_pc) begin failures++; $display("FAIL stall_resume got=%0d/%h exp=4/%h", cyc, bus.oCurrent_PC, exp_pc); end
   endtask

   task automatic test_reset_mid();
      int n; logic [31:0] v;
      cur_instr = 32'h04102023; dm_stall = 20; n = 0;
      while (!(bus.oState == 3'd3 && bus.oWR) && n < 10) begin tick(); n++; end
      checks++; if (bus.oWR !== 1'b1) begin failures++; $display("FAIL rmid_reach got=%b exp=1", bus.oWR); end
      rst = 1'b1; #1;
      checks++; if (bus.oWR !== 1'b0) begin failures++; $display("FAIL rmid_wr_drop got=%b exp=0", bus.oWR); end
      @(posedge clk); #1;
      checks++; if (bus.oWR !== 1'b0 || bus.oState !== 3'd0 || bus.oCurrent_PC !== 32'd0) begin failures++; $display("FAIL rmid_after got=%b/%0d/%h exp=0/0/0", bus.oWR, bus.oState, bus.oCurrent_PC); end
      rst = 1'b0; dm_stall = 0; exp_pc = 32'd0;
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      for (int i = 0; i < 32; i++) begin
         rd_reg(i, v);
         checks++; if (v !== model[i]) begin failures++; $display("FAIL rmid_reg x%0d got=%h exp=%h", i, v, model[i]); end
      end
   endtask

   task automatic test_illegal();
      int cyc; logic [31:0] v;
      cur_instr = 32'h00500093; model[1] = 32'd5; exec_one(cyc); exp_pc += 4;
      cur_instr = 32'hFFFFFFFF;
`ifdef CPU_MC_ILLEGAL_TRAP_EN
      for (int i = 0; i < 3; i++) tick();
      checks++; if (bus.oHalt !== 1'b1 || bus.oState !== 3'd5) begin failures++; $display("FAIL halt_enter got=%b/%0d exp=1/5", bus.oHalt, bus.oState); end
      for (int i = 0; i < 4; i++) tick();
      checks++; if (bus.oState !== 3'd5 || bus.oCurrent_PC !== exp_pc || bus.oIM_Req !== 1'b0) begin failures++; $display("FAIL halt_hold got=%0d/%h/%b exp=5/%h/0", bus.oState, bus.oCurrent_PC, bus.oIM_Req, exp_pc); end
`else
      exec_one(cyc); exp_pc += 4;
      checks++; if (cyc !== 3 || bus.oCurrent_PC !== exp_pc || bus.oHalt !== 1'b0) begin failures++; $display("FAIL illegal_nop got=%0d/%h/%b exp=3/%h/0", cyc, bus.oCurrent_PC, bus.oHalt, exp_pc); end
`endif
      for (int i = 0; i < 32; i++) begin
         rd_reg(i, v);
         checks++; if (v !== model[i]) begin failures++; $display("FAIL illegal_reg x%0d got=%h exp=%h", i, v, model[i]); end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      bus.iIM_Ready = 1'b0; bus.iIM_Data = NOP; bus.iDM_Ready = 1'b0;
      bus.iReadData = 32'd0; bus.iDbg_RA = 5'd0;
      cur_instr = NOP; im_stall = 0; dm_stall = 0; exp_pc = 32'd0;
      test_reset();
      test_addi();
      test_alu();
      test_mem();
      test_branch();
      test_fetch_stall();
      test_reset_mid();
      test_illegal();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
